// File: rtl/light_phase_scheduler.sv
// Highway/country intersection phase sequencer with tick-counted dwells and emergency all-red override.
// Lamp outputs are registered from next state (change on the state edge); no backpressure, input-driven only.
module light_phase_scheduler #(
   parameter int CNT_W           = 8,
   parameter int Y2R_DLY         = 3,
   parameter int R2G_DLY         = 2,
   parameter int MIN_HWY_GREEN   = 10,
   parameter int MAX_CNTRY_GREEN = 20
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       tick,
   input  logic       x,
   input  logic       emerg,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic [2:0] phase,
   output logic       changed
);

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5
   } state_t;

   localparam logic [1:0] LAMP_RED = 2'b01;
   localparam logic [1:0] LAMP_YEL = 2'b10;
   localparam logic [1:0] LAMP_GRN = 2'b11;

   localparam logic [CNT_W-1:0] Y2R_C = CNT_W'(Y2R_DLY);
   localparam logic [CNT_W-1:0] R2G_C = CNT_W'(R2G_DLY);
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HWY_GREEN);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNTRY_GREEN);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       hwy_d, cntry_d;

   assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         HG: begin
            if (emerg) begin
               state_d = HY;
               cnt_d   = '0;
            end else if (tick) begin
               if (x && (cnt_q >= MIN_C)) begin
                  state_d = HY;
                  cnt_d   = '0;
               end else if (cnt_q < MIN_C) begin
                  cnt_d = cnt_inc;
               end
            end
         end
         HY: begin
            if (tick) begin
               if (cnt_inc == Y2R_C) begin
                  state_d = AR1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         AR1: begin
            // Held at zero so the full all-red dwell runs once emerg drops.
            if (emerg) begin
               cnt_d = '0;
            end else if (tick) begin
               if (cnt_inc == R2G_C) begin
                  state_d = CG;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         CG: begin
            if (emerg) begin
               state_d = CY;
               cnt_d   = '0;
            end else if (tick) begin
               if (!x || (cnt_inc == MAX_C)) begin
                  state_d = CY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         CY: begin
            if (tick) begin
               if (cnt_inc == Y2R_C) begin
                  state_d = AR2;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         AR2: begin
            if (emerg) begin
               cnt_d = '0;
            end else if (tick) begin
               if (cnt_inc == R2G_C) begin
                  state_d = HG;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = HG;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      hwy_d   = LAMP_GRN;
      cntry_d = LAMP_RED;
      case (state_d)
         HG:  begin hwy_d = LAMP_GRN; cntry_d = LAMP_RED; end
         HY:  begin hwy_d = LAMP_YEL; cntry_d = LAMP_RED; end
         AR1: begin hwy_d = LAMP_RED; cntry_d = LAMP_RED; end
         CG:  begin hwy_d = LAMP_RED; cntry_d = LAMP_GRN; end
         CY:  begin hwy_d = LAMP_RED; cntry_d = LAMP_YEL; end
         AR2: begin hwy_d = LAMP_RED; cntry_d = LAMP_RED; end
         default: begin hwy_d = LAMP_GRN; cntry_d = LAMP_RED; end
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= HG;
         cnt_q   <= '0;
         hwy     <= LAMP_GRN;
         cntry   <= LAMP_RED;
         phase   <= 3'd0;
         changed <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hwy     <= hwy_d;
         cntry   <= cntry_d;
         phase   <= state_d;
         changed <= (state_d != state_q);
      end
   end

endmodule

// File: tb/tb_light_phase_scheduler.sv
// Bench for light_phase_scheduler: segment table of expected phase timelines plus hand-written corner sequences.
module tb_light_phase_scheduler;

   localparam logic [2:0] P_HG = 3'd0, P_HY = 3'd1, P_AR1 = 3'd2,
                          P_CG = 3'd3, P_CY = 3'd4, P_AR2 = 3'd5;

   logic       clock = 1'b0;
   logic       clear_n = 1'b0;
   logic       tick = 1'b0;
   logic       x = 1'b0;
   logic       emerg = 1'b0;
   logic [1:0] hwy, cntry;
   logic [2:0] phase;
   logic       changed;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];

   typedef struct {
      bit         rst;
      int         n;
      int         tper;
      bit         xi;
      bit         em;
      logic [2:0] cur;
      logic [2:0] nxt;
   } seg_t;

   seg_t tbl[$];

   light_phase_scheduler dut (
      .clock  (clock),
      .clear_n(clear_n),
      .tick   (tick),
      .x      (x),
      .emerg  (emerg),
      .hwy    (hwy),
      .cntry  (cntry),
      .phase  (phase),
      .changed(changed)
   );

   always #5 clock = ~clock;

   function automatic logic [3:0] lamps(input logic [2:0] ph);
      case (ph)
         P_HG:    return 4'b11_01;
         P_HY:    return 4'b10_01;
         P_AR1:   return 4'b01_01;
         P_CG:    return 4'b01_11;
         P_CY:    return 4'b01_10;
         P_AR2:   return 4'b01_01;
         default: return 4'b00_00;
      endcase
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got phase=%0d hwy=%b cntry=%b chg=%b, want phase=%0d hwy=%b cntry=%b chg=%b",
                  nm, act[7:5], act[4:3], act[2:1], act[0], exp[7:5], exp[4:3], exp[2:1], exp[0]);
      end
   endtask

   task automatic step(input bit t, input bit xi, input bit em,
                       input logic [2:0] eph, input bit echg, input string nm);
      logic [7:0] e;
      @(negedge clock);
      tick  = t;
      x     = xi;
      emerg = em;
      exp_q.push_back({eph, lamps(eph), echg});
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check(nm, {phase, hwy, cntry, changed}, e);
   endtask

   task automatic do_reset();
      @(negedge clock);
      tick    = 1'b0;
      x       = 1'b0;
      emerg   = 1'b0;
      clear_n = 1'b0;
      #1;
      check("reset", {phase, hwy, cntry, changed}, {P_HG, 4'b11_01, 1'b0});
      @(posedge clock);
      @(posedge clock);
      #2 clear_n = 1'b1;
   endtask

   task automatic add(input bit rst, input int n, input int tper, input bit xi, input bit em,
                      input logic [2:0] cur, input logic [2:0] nxt);
      seg_t s;
      s.rst = rst; s.n = n; s.tper = tper; s.xi = xi; s.em = em; s.cur = cur; s.nxt = nxt;
      tbl.push_back(s);
   endtask

   task automatic run_seg(input seg_t s, input int idx);
      bit t;
      for (int j = 0; j < s.n; j++) begin
         t = ((j % s.tper) == (s.tper - 1));
         if (j == s.n - 1)
            step(t, s.xi, s.em, s.nxt, s.nxt != s.cur, $sformatf("seg%0d_end", idx));
         else
            step(t, s.xi, s.em, s.cur, 1'b0, $sformatf("seg%0d_c%0d", idx, j));
      end
   endtask

   initial begin
      // x low forever: highway green holds
      add(1, 100, 1, 0, 0, P_HG, P_HG);
      // x high: full cycle, country green ends on MAX
      add(1, 11, 1, 1, 0, P_HG,  P_HY);
      add(0,  3, 1, 1, 0, P_HY,  P_AR1);
      add(0,  2, 1, 1, 0, P_AR1, P_CG);
      add(0, 20, 1, 1, 0, P_CG,  P_CY);
      add(0,  3, 1, 1, 0, P_CY,  P_AR2);
      add(0,  2, 1, 1, 0, P_AR2, P_HG);
      // x drops before edge 20
      add(1, 11, 1, 1, 0, P_HG,  P_HY);
      add(0,  3, 1, 1, 0, P_HY,  P_AR1);
      add(0,  2, 1, 1, 0, P_AR1, P_CG);
      add(0,  3, 1, 1, 0, P_CG,  P_CG);
      add(0,  1, 1, 0, 0, P_CG,  P_CY);
      add(0,  3, 1, 0, 0, P_CY,  P_AR2);
      add(0,  2, 1, 0, 0, P_AR2, P_HG);
      // tick every 4th cycle
      add(1, 44, 4, 1, 0, P_HG,  P_HY);
      add(0, 12, 4, 1, 0, P_HY,  P_AR1);
      add(0,  8, 4, 1, 0, P_AR1, P_CG);
      add(0, 80, 4, 1, 0, P_CG,  P_CY);
      // emergency during country green, all-red hold, release
      add(1, 11, 1, 1, 0, P_HG,  P_HY);
      add(0,  3, 1, 1, 0, P_HY,  P_AR1);
      add(0,  2, 1, 1, 0, P_AR1, P_CG);
      add(0,  3, 1, 1, 0, P_CG,  P_CG);
      add(0,  1, 1, 1, 1, P_CG,  P_CY);
      add(0,  3, 1, 1, 1, P_CY,  P_AR2);
      add(0,  6, 1, 1, 1, P_AR2, P_AR2);
      add(0,  2, 1, 1, 0, P_AR2, P_HG);
      // emergency in HG without tick, dwell in HY, hold in AR1, x low exits CG on first tick
      add(1,  1, 4, 0, 1, P_HG,  P_HY);
      add(0,  3, 1, 0, 1, P_HY,  P_AR1);
      add(0,  4, 1, 0, 1, P_AR1, P_AR1);
      add(0,  2, 1, 0, 0, P_AR1, P_CG);
      add(0,  1, 1, 0, 0, P_CG,  P_CY);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         run_seg(tbl[i], i);
      end

      // x pulses only on non-tick cycles must not leave HG
      do_reset();
      for (int j = 0; j < 60; j++) begin
         bit t;
         t = ((j % 4) == 3);
         step(t, !t, 1'b0, P_HG, 1'b0, "x_nontick");
      end

      // asynchronous reset in the middle of HY
      do_reset();
      for (int j = 0; j < 11; j++)
         step(1'b1, 1'b1, 1'b0, (j == 10) ? P_HY : P_HG, j == 10, "pre_mid_rst");
      step(1'b1, 1'b1, 1'b0, P_HY, 1'b0, "in_hy");
      #3 clear_n = 1'b0;
      #1;
      check("async_rst_mid_hy", {phase, hwy, cntry, changed}, {P_HG, 4'b11_01, 1'b0});
      @(posedge clock);
      #2 clear_n = 1'b1;
      for (int j = 0; j < 11; j++)
         step(1'b1, 1'b1, 1'b0, (j == 10) ? P_HY : P_HG, j == 10, "min_restart");

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/light_phase_scheduler.md
Name: light_phase_scheduler

Overview:
Timed phase sequencer for the highway/country-road intersection. It drives the hwy/cntry lamp codes through green, yellow and all-red phases. Every dwell is measured in timebase ticks, with a programmable minimum highway green and a maximum country green. It also provides an emergency override that forces both roads to red. It replaces free-running next-state stepping with counted delays and sits between the sensor/timebase logic and the lamp drivers.

Parameters:
CNT_W, 8, dwell counter width.
Y2R_DLY, 3, yellow duration in ticks (>=1).
R2G_DLY, 2, all-red duration in ticks (>=1).
MIN_HWY_GREEN, 10, ticks highway green must be held before a country request is honoured (>=0).
MAX_CNTRY_GREEN, 20, maximum country green in ticks (>=1).
All parameters must be < 2^CNT_W.

Ports:
clock  in  1  system clock, rising-edge.
clear_n  in  1  asynchronous active-low reset.
tick  in  1  one-cycle timebase enable; all dwell counting is gated by it.
x  in  1  country-road vehicle sensor, synchronous; sampled only on tick cycles.
emerg  in  1  emergency override; sampled every cycle, not tick-gated.
hwy  out  2  highway lamp: red=2'b01, yellow=2'b10, green=2'b11.
cntry  out  2  country lamp, same encoding.
phase  out  3  current state code.
changed  out  1  one-cycle pulse on the cycle after any state change.

Behaviour:
- Reset (clear_n=0, asynchronous): state=HG, cnt=0, hwy=11, cntry=01, phase=0, changed=0. Outputs take these values immediately, without waiting for a clock edge.
- States and codes:
  - HG=0: hwy green, cntry red.
  - HY=1: hwy yellow, cntry red.
  - AR1=2: both red.
  - CG=3: hwy red, cntry green.
  - CY=4: hwy red, cntry yellow.
  - AR2=5: both red.
  - Codes 6 and 7 are illegal and recover to HG on the next edge.
- Outputs are registered and decoded from next-state, so the lamp codes change on the same edge as the state.
- cnt is cleared to 0 on every state entry. A transition happens only on an edge where its condition holds.
- Fixed-dwell rule for HY, AR1, CY and AR2:
  - On a tick edge, if cnt+1 == DUR, advance; otherwise cnt increments.
  - Each of these states therefore lasts exactly DUR ticks.
  - DUR is Y2R_DLY for HY and CY, and R2G_DLY for AR1 and AR2.
- HG:
  - On a tick edge, if x==1 and cnt >= MIN_HWY_GREEN, go to HY.
  - Otherwise cnt increments, saturating at MIN_HWY_GREEN.
  - With x held low, HG holds forever.
- CG:
  - On a tick edge, if x==0 or cnt+1 == MAX_CNTRY_GREEN, go to CY. Otherwise cnt increments.
  - The MAX limit applies even if x stays high.
  - On the first tick edge in CG, x==0 exits immediately.
- Transition order: HY->AR1->CG->CY->AR2->HG.
- Emergency override:
  - emerg=1 in HG: go to HY on the next edge, regardless of tick and MIN.
  - emerg=1 in CG: go to CY on the next edge.
  - emerg=1 in HY or CY: the fixed dwell continues.
  - emerg=1 in AR1 or AR2: hold; cnt is frozen at 0 and does not count.
  - After emerg falls, an all-red state runs its full R2G_DLY ticks.
  - emerg has priority over x, MIN and MAX.
- changed is registered and equals 1 iff state differs from the state one cycle earlier. It is never high in the first cycle after reset release.
- Reset asserted mid-phase (for example during HY) returns to HG at once; there is no yellow first.

Test Plan:
1. Reset, then tick=1 every cycle, x=0, emerg=0 for 100 cycles -> hwy=11, cntry=01, phase=0 throughout, changed never 1.
2. tick=1 every cycle, x=1 from reset release (edge 1) -> HY at edge 11, AR1 at edge 14, CG at edge 16, CY at edge 36 (MAX limit), AR2 at edge 39, HG at edge 41. changed pulses one cycle after each of these edges.
3. Same as scenario 2, but x drops to 0 just before edge 20 -> CY at edge 20, AR2 at edge 23, HG at edge 25.
4. tick on every 4th cycle, x=1 -> HY dwell is exactly 12 cycles. x pulses on non-tick cycles are ignored (exit from HG is not taken).
5. Drive scenario 2 to CG, assert emerg for 10 cycles (tick=1) -> CY on the next edge, then AR2 after 3 ticks. AR2 holds both red (01/01) while emerg=1. HG follows 2 ticks after emerg falls.
6. Assert clear_n=0 mid-HY (phase=1) between clock edges -> hwy=11, cntry=01, phase=0 before the next edge. After release, the MIN_HWY_GREEN count restarts from 0.
